ise_sort_engine: RTL and testbench
==================================

ISE_SORT_ENGINE -- requirements
Module: ise_sort_engine

Interface
REQ-001 Parameter IMG_NUM, 32, images per batch (>=2); IDX_W = clog2(IMG_NUM) derived.
REQ-002 Parameter IMG_PIX, 16384, pixels per image (>=1); PIX_W = clog2(IMG_PIX+1) derived.
REQ-003 Parameter CH_W, 8, bits per colour channel.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  pixel_in/image_in_index valid this cycle.
REQ-007 image_in_index  in  IDX_W  tag of the image the pixel belongs to.
REQ-008 pixel_in  in  3*CH_W  {R,G,B}, R in MSBs.
REQ-009 busy  out  1  high = input not accepted this cycle.
REQ-010 out_valid  out  1  result beat valid.
REQ-011 color_index  out  2  image class: 0=R, 1=G, 2=B.
REQ-012 image_out_index  out  IDX_W  tag of the sorted image.

Function
REQ-013 Pixel accepted on a rising edge iff in_valid=1 and busy=0; in_valid gaps are allowed anywhere.
REQ-014 Images arrive contiguously, IMG_PIX accepted pixels each; image_in_index is sampled on the first pixel of each image.
REQ-015 Pixel class = channel with largest value; ties resolved R>G>B.
REQ-016 Per image, keep cnt_R/G/B (PIX_W bits) and sum_R/G/B (CH_W+PIX_W bits); a pixel adds its winning channel value to that class's sum only.
REQ-017 Image class = class with largest count; ties R>G>B.
REQ-018 Intensity = floor(sum_class / cnt_class), CH_W bits, computed by a sequential restoring divider of one quotient bit per cycle.
REQ-019 States: ACC (accepting), SEL (1 cycle, latch class), DIV (CH_W cycles), INS (1 cycle), OUT.
REQ-020 busy rises the cycle after the last pixel of an image is accepted and stays high for CH_W+2 cycles (SEL+DIV+INS), then returns to ACC with cleared counters/sums.
REQ-021 INS inserts record {class, intensity, tag} into an IMG_NUM-entry sorted list in one cycle; key class ascending, then intensity ascending, equal keys in arrival order (stable).
REQ-022 After INS of image IMG_NUM, go to OUT with busy held high: out_valid high for exactly IMG_NUM consecutive cycles emitting list entries in order, starting the cycle after INS.
REQ-023 The cycle after the last beat: out_valid=0, busy=0, list empty, state ACC; next batch may start immediately.
REQ-024 color_index/image_out_index hold 0 when out_valid=0.
REQ-025 Inputs while busy=1 are ignored regardless of in_valid.

Reset
REQ-026 reset=0 asynchronously forces busy=0, out_valid=0, color_index=0, image_out_index=0, state ACC, all counters, sums, divider and list cleared.
REQ-027 Reset during any state discards the partial image and batch; no out_valid appears for discarded data.

Configuration
REQ-028 Macro ISE_INTENSITY_OUT_EN defined: extra output intensity_out (CH_W bits) carries the beat's intensity while out_valid=1, else 0; reset value 0.
REQ-029 Macro undefined: port intensity_out absent; all other behaviour identical.

Verification
REQ-030 IMG_NUM=4, IMG_PIX=4, CH_W=8; image tag 2 all pixels 0x801010 -> class 0, intensity 0x80, busy high exactly 10 cycles after last pixel.
REQ-031 Pixels 0x404000, 0x004040, 0x400040, 0x000000 -> classes R,G,R,R; image class 0, intensity (0x40+0x40+0x00)/3 = 0x2A.
REQ-032 Tags 0..3 with (class,intensity) = (B,0x10),(R,0x90),(R,0x20),(R,0x20) -> out beats tags 2,3,1,0 with colours 0,0,0,2 on 4 consecutive cycles; busy falls the cycle after.
REQ-033 in_valid toggled 1/0 every cycle throughout a batch -> identical results to REQ-032; no pixel double-counted.
REQ-034 reset pulled low mid-image and mid-OUT -> outputs 0 immediately; fresh batch afterwards produces correct 4 beats.
REQ-035 With ISE_INTENSITY_OUT_EN, REQ-032 beats show intensity_out 0x20,0x20,0x90,0x10; without it, build elaborates with no such port.

Source files
------------

// File: rtl/ise_sort_engine.sv
// ise_sort_engine: classifies each pixel of an image by its dominant colour channel, gives the
// image the majority class and the mean winning-channel intensity of that class, and keeps a
// sorted list of image records. A full batch is streamed out in order.
// Optional build macro: ISE_INTENSITY_OUT_EN adds the intensity_out port.
module ise_sort_engine #(
    parameter int unsigned IMG_NUM = 32,
    parameter int unsigned IMG_PIX = 16384,
    parameter int unsigned CH_W    = 8,
    localparam int unsigned IDX_W  = $clog2(IMG_NUM),
    localparam int unsigned PIX_W  = $clog2(IMG_PIX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    image_in_index,
    input  logic [3*CH_W-1:0]   pixel_in,
    output logic                busy,
    output logic                out_valid,
    output logic [1:0]          color_index,
    output logic [IDX_W-1:0]    image_out_index
`ifdef ISE_INTENSITY_OUT_EN
    ,
    output logic [CH_W-1:0]     intensity_out
`endif
);

    localparam int unsigned SUM_W  = CH_W + PIX_W;
    localparam int unsigned KEY_W  = 2 + CH_W;
    localparam int unsigned DCNT_W = $clog2(CH_W + 1);

    localparam logic [2:0] ST_ACC = 3'd0;
    localparam logic [2:0] ST_SEL = 3'd1;
    localparam logic [2:0] ST_DIV = 3'd2;
    localparam logic [2:0] ST_INS = 3'd3;
    localparam logic [2:0] ST_OUT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]  tag_q, tag_d;
    logic [PIX_W-1:0]  cnt_q [3];
    logic [PIX_W-1:0]  cnt_d [3];
    logic [SUM_W-1:0]  sum_q [3];
    logic [SUM_W-1:0]  sum_d [3];
    logic [1:0]        cls_q, cls_d;
    logic [SUM_W-1:0]  rem_q, rem_d;
    logic [SUM_W-1:0]  dsr_q, dsr_d;
    logic [CH_W-1:0]   quot_q, quot_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [KEY_W-1:0]  key_q  [IMG_NUM];
    logic [KEY_W-1:0]  key_d  [IMG_NUM];
    logic [IDX_W-1:0]  ltag_q [IMG_NUM];
    logic [IDX_W-1:0]  ltag_d [IMG_NUM];
    logic [IDX_W:0]    n_q, n_d;
    logic [IDX_W-1:0]  optr_q, optr_d;

    logic [CH_W-1:0]   pix_r, pix_g, pix_b, pix_val;
    logic [1:0]        pix_cls;
    logic [1:0]        img_cls;
    logic [KEY_W-1:0]  new_key;
    logic [IMG_NUM-1:0] keep;

    // Pixel class: dominant channel, ties resolved R over G over B.
    always_comb begin
        pix_r = pixel_in[3*CH_W-1 -: CH_W];
        pix_g = pixel_in[2*CH_W-1 -: CH_W];
        pix_b = pixel_in[CH_W-1:0];
        if (pix_r >= pix_g && pix_r >= pix_b) begin
            pix_cls = 2'd0;
            pix_val = pix_r;
        end else if (pix_g >= pix_b) begin
            pix_cls = 2'd1;
            pix_val = pix_g;
        end else begin
            pix_cls = 2'd2;
            pix_val = pix_b;
        end
    end

    // Image class: largest pixel count, ties resolved R over G over B.
    always_comb begin
        if (cnt_q[0] >= cnt_q[1] && cnt_q[0] >= cnt_q[2]) begin
            img_cls = 2'd0;
        end else if (cnt_q[1] >= cnt_q[2]) begin
            img_cls = 2'd1;
        end else begin
            img_cls = 2'd2;
        end
    end

    // Sorted-list prefix whose keys are <= the new key; new record lands right after it (stable).
    always_comb begin
        new_key = {cls_q, quot_q};
        for (int i = 0; i < IMG_NUM; i++) begin
            keep[i] = ((IDX_W+1)'(i) < n_q) && (key_q[i] <= new_key);
        end
    end

    // Next-state logic for the accumulate / select / divide / insert / output sequence.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        tag_d     = tag_q;
        cls_d     = cls_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        quot_d    = quot_q;
        dcnt_d    = dcnt_q;
        n_d       = n_q;
        optr_d    = optr_q;
        for (int c = 0; c < 3; c++) begin
            cnt_d[c] = cnt_q[c];
            sum_d[c] = sum_q[c];
        end
        for (int i = 0; i < IMG_NUM; i++) begin
            key_d[i]  = key_q[i];
            ltag_d[i] = ltag_q[i];
        end

        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (pix_cnt_q == '0) begin
                        tag_d = image_in_index;
                    end
                    cnt_d[pix_cls] = cnt_q[pix_cls] + 1'b1;
                    sum_d[pix_cls] = sum_q[pix_cls] + SUM_W'(pix_val);
                    if (pix_cnt_q == PIX_W'(IMG_PIX - 1)) begin
                        pix_cnt_d = '0;
                        state_d   = ST_SEL;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_SEL: begin
                // Divisor pre-shifted so the quotient MSB is resolved first.
                cls_d  = img_cls;
                rem_d  = sum_q[img_cls];
                dsr_d  = SUM_W'(cnt_q[img_cls]) << (CH_W - 1);
                quot_d = '0;
                dcnt_d = '0;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                // Mean never exceeds a channel value, so CH_W quotient bits always suffice.
                if (rem_q >= dsr_q) begin
                    rem_d  = rem_q - dsr_q;
                    quot_d = (quot_q << 1) | CH_W'(1);
                end else begin
                    quot_d = quot_q << 1;
                end
                dsr_d = dsr_q >> 1;
                if (dcnt_q == DCNT_W'(CH_W - 1)) begin
                    state_d = ST_INS;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_INS: begin
                if (!keep[0]) begin
                    key_d[0]  = new_key;
                    ltag_d[0] = tag_q;
                end
                for (int i = 1; i < IMG_NUM; i++) begin
                    if (!keep[i]) begin
                        if (keep[i-1]) begin
                            key_d[i]  = new_key;
                            ltag_d[i] = tag_q;
                        end else begin
                            key_d[i]  = key_q[i-1];
                            ltag_d[i] = ltag_q[i-1];
                        end
                    end
                end
                n_d = n_q + 1'b1;
                for (int c = 0; c < 3; c++) begin
                    cnt_d[c] = '0;
                    sum_d[c] = '0;
                end
                if (n_q == (IDX_W+1)'(IMG_NUM - 1)) begin
                    optr_d  = '0;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (optr_q == IDX_W'(IMG_NUM - 1)) begin
                    optr_d  = '0;
                    n_d     = '0;
                    state_d = ST_ACC;
                end else begin
                    optr_d = optr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ACC;
            pix_cnt_q <= '0;
            tag_q     <= '0;
            cls_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            quot_q    <= '0;
            dcnt_q    <= '0;
            n_q       <= '0;
            optr_q    <= '0;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= '0;
                sum_q[c] <= '0;
            end
            for (int i = 0; i < IMG_NUM; i++) begin
                key_q[i]  <= '0;
                ltag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            tag_q     <= tag_d;
            cls_q     <= cls_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            quot_q    <= quot_d;
            dcnt_q    <= dcnt_d;
            n_q       <= n_d;
            optr_q    <= optr_d;
            for (int c = 0; c < 3; c++) begin
                cnt_q[c] <= cnt_d[c];
                sum_q[c] <= sum_d[c];
            end
            for (int i = 0; i < IMG_NUM; i++) begin
                key_q[i]  <= key_d[i];
                ltag_q[i] <= ltag_d[i];
            end
        end
    end

    // Outputs decoded from state; beat fields forced to zero outside the output phase.
    always_comb begin
        busy            = (state_q != ST_ACC);
        out_valid       = (state_q == ST_OUT);
        color_index     = '0;
        image_out_index = '0;
`ifdef ISE_INTENSITY_OUT_EN
        intensity_out   = '0;
`endif
        if (state_q == ST_OUT) begin
            color_index     = key_q[optr_q][KEY_W-1 -: 2];
            image_out_index = ltag_q[optr_q];
`ifdef ISE_INTENSITY_OUT_EN
            intensity_out   = key_q[optr_q][CH_W-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_ise_sort_engine.sv
// Scoreboard bench for ise_sort_engine (IMG_NUM=4, IMG_PIX=4, CH_W=8).
module tb_ise_sort_engine;

    localparam int unsigned IMG_NUM = 4;
    localparam int unsigned IMG_PIX = 4;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned IDX_W   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [IDX_W-1:0] image_in_index = '0;
    logic [23:0]      pixel_in = '0;
    logic             busy;
    logic             out_valid;
    logic [1:0]       color_index;
    logic [IDX_W-1:0] image_out_index;
`ifdef ISE_INTENSITY_OUT_EN
    logic [CH_W-1:0]  intensity_out;
`endif

    always #5 clk = ~clk;

    ise_sort_engine #(
        .IMG_NUM (IMG_NUM),
        .IMG_PIX (IMG_PIX),
        .CH_W    (CH_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .image_in_index  (image_in_index),
        .pixel_in        (pixel_in),
        .busy            (busy),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index)
`ifdef ISE_INTENSITY_OUT_EN
        ,
        .intensity_out   (intensity_out)
`endif
    );

    typedef struct packed {
        logic [1:0] cls;
        logic [7:0] inten;
        logic [1:0] tag;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    beats_total = 0;
    bit    toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: pops expected beats, checks beat-run and busy-run lengths.
    int    busy_run = 0;
    int    beat_run = 0;
    bit    prev_busy = 1'b0;
    bit    prev_ov = 1'b0;
    bit    saw_beat = 1'b0;
    beat_t e;

    always @(negedge clk) begin
        if (!reset) begin
            busy_run  = 0;
            beat_run  = 0;
            saw_beat  = 1'b0;
            prev_busy = 1'b0;
            prev_ov   = 1'b0;
        end else begin
            if (out_valid) begin
                beat_run++;
                saw_beat = 1'b1;
                beats_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got tag %0d colour %0d, required no beat",
                             image_out_index, color_index);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_colour", 32'(color_index), 32'(e.cls));
                    check("beat_tag", 32'(image_out_index), 32'(e.tag));
`ifdef ISE_INTENSITY_OUT_EN
                    check("beat_intensity", 32'(intensity_out), 32'(e.inten));
`endif
                end
            end else if (prev_ov) begin
                check("beat_run_len", 32'(beat_run), 32'(IMG_NUM));
                check("idle_colour", 32'(color_index), 32'd0);
                check("idle_tag", 32'(image_out_index), 32'd0);
                check("busy_after_out", 32'(busy), 32'd0);
                beat_run = 0;
            end
            if (busy) begin
                busy_run++;
            end else if (prev_busy) begin
                check("busy_run_len", 32'(busy_run), saw_beat ? 32'(CH_W + 2 + IMG_NUM)
                                                              : 32'(CH_W + 2));
                busy_run = 0;
                saw_beat = 1'b0;
            end
            prev_busy = busy;
            prev_ov   = out_valid;
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_pixel(input logic [1:0] tag, input logic [23:0] pix);
        int n = 0;
        while (busy && n < 100) begin
            // Junk offered while busy must be ignored.
            in_valid       = 1'b1;
            image_in_index = ~tag;
            pixel_in       = 24'hFFFFFF;
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        in_valid       = 1'b1;
        image_in_index = tag;
        pixel_in       = pix;
        @(negedge clk);
        if (toggle) begin
            in_valid = 1'b0;
            pixel_in = 24'h0;
            @(negedge clk);
        end
    endtask

    // Tag only valid on the first pixel; later pixels carry a wrong tag on purpose.
    task automatic send_image(input logic [1:0] tag, input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
        send_pixel(tag, p0);
        send_pixel(~tag, p1);
        send_pixel(~tag, p2);
        send_pixel(~tag, p3);
    endtask

    // Batch: tags 0..3 = (B,0x10),(R,0x90),(R,0x20),(R,0x20) -> beats tags 2,3,1,0.
    task automatic batch_b();
        exp_q.push_back('{cls: 2'd0, inten: 8'h20, tag: 2'd2});
        exp_q.push_back('{cls: 2'd0, inten: 8'h20, tag: 2'd3});
        exp_q.push_back('{cls: 2'd0, inten: 8'h90, tag: 2'd1});
        exp_q.push_back('{cls: 2'd2, inten: 8'h10, tag: 2'd0});
        send_image(2'd0, 24'h000010, 24'h000010, 24'h000010, 24'h000010);
        send_image(2'd1, 24'h900000, 24'h900000, 24'h900000, 24'h900000);
        send_image(2'd2, 24'h200000, 24'h200000, 24'h200000, 24'h200000);
        send_image(2'd3, 24'h200000, 24'h200000, 24'h200000, 24'h200000);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        pixel_in = 24'h0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag_s);
        check({tag_s, "_busy"}, 32'(busy), 32'd0);
        check({tag_s, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag_s, "_colour"}, 32'(color_index), 32'd0);
        check({tag_s, "_tag"}, 32'(image_out_index), 32'd0);
`ifdef ISE_INTENSITY_OUT_EN
        check({tag_s, "_intensity"}, 32'(intensity_out), 32'd0);
`endif
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        // Batch A: tag2 0x801010 -> (R,0x80); tag0 mixed -> (R,0x2A);
        // tag1 -> (B,0x10); tag3 G/B count tie -> (G,0xFF).
        exp_q.push_back('{cls: 2'd0, inten: 8'h2A, tag: 2'd0});
        exp_q.push_back('{cls: 2'd0, inten: 8'h80, tag: 2'd2});
        exp_q.push_back('{cls: 2'd1, inten: 8'hFF, tag: 2'd3});
        exp_q.push_back('{cls: 2'd2, inten: 8'h10, tag: 2'd1});
        send_image(2'd2, 24'h801010, 24'h801010, 24'h801010, 24'h801010);
        send_image(2'd0, 24'h404000, 24'h004040, 24'h400040, 24'h000000);
        send_image(2'd1, 24'h000010, 24'h000010, 24'h000010, 24'h000010);
        send_image(2'd3, 24'h00FF00, 24'h00FF00, 24'h000030, 24'h000050);

        // Back-to-back batch with continuous in_valid.
        batch_b();
        drain();

        // Same batch with in_valid toggling every cycle.
        toggle = 1'b1;
        batch_b();
        toggle = 1'b0;
        drain();

        // Reset mid-image: partial image discarded.
        send_pixel(2'd1, 24'hFF0000);
        send_pixel(2'd1, 24'hFF0000);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_outputs_zero("rst_mid_image");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-output: remaining beats dropped.
        base = beats_total;
        batch_b();
        in_valid = 1'b0;
        n = 0;
        while (beats_total < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (beats_total < base + 2) begin
            checks++;
            $display("FAIL mid_out_timeout: %0d beats, required %0d", beats_total - base, 2);
        end
        #2 check("mid_out_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        #1 check_outputs_zero("rst_mid_out");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fresh batch after reset.
        batch_b();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
